// File: rtl/seg_display_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_sched_if
// Description : Message request/acknowledge bundle for the display scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_display_sched_if;
    logic [31:0] msgSeg;
    logic        msgReq;
    logic        msgBlink;
    logic        msgAck;
    logic        msgBusy;

    modport master (
        output msgSeg,
        output msgReq,
        output msgBlink,
        input  msgAck,
        input  msgBusy
    );

    modport slave (
        input  msgSeg,
        input  msgReq,
        input  msgBlink,
        output msgAck,
        output msgBusy
    );
endinterface
`default_nettype wire

// File: rtl/seg_display_sched.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_sched
// Description : 4-digit seven-segment scan controller with base/message
//               source scheduling, timed messages and optional blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_sched #(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_CYCLES = 200000000,
    parameter int BLINK_DIV   = 50000000
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [31:0]       baseSeg,
    seg_display_sched_if.slave     msg,
    output logic [3:0]             anode,
    output logic [7:0]             segOut
);

    localparam int c_REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_BLINK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

    localparam logic [c_REF_W-1:0]   c_REF_LAST   = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_REF_W-1:0]    r_ref_cnt;
    logic [1:0]            r_idx;
    logic [31:0]           r_frame;
    logic [31:0]           r_msg;
    logic                  r_blink_en;
    logic                  r_phase;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_BLINK_W-1:0]  r_blink_cnt;
    logic                  r_req_d;
    logic                  r_ack;
    logic [3:0]            r_anode;
    logic [7:0]            r_seg;

    logic                  w_ref_wrap;
    logic                  w_frame_end;
    logic                  w_accept;
    logic                  w_hold_done;
    logic                  w_blink_wrap;
    logic                  w_blank_nxt;
    logic [3:0]            w_anode_dec;
    logic [7:0]            w_seg_sel;

    assign w_ref_wrap   = (r_ref_cnt == c_REF_LAST);
    assign w_frame_end  = w_ref_wrap && (r_idx == 2'd3);
    assign w_accept     = msg.msgReq & ~r_req_d;
    assign w_hold_done  = (r_hold_cnt == c_HOLD_LAST);
    assign w_blink_wrap = (r_blink_cnt == c_BLINK_LAST);

    // Digit timing; the frame only changes at a frame boundary so a scan
    // never mixes base and message bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt <= '0;
            r_idx     <= 2'd0;
            r_frame   <= 32'hFFFF_FFFF;
        end else begin
            if (w_ref_wrap) begin
                r_ref_cnt <= '0;
                r_idx     <= r_idx + 2'd1;
            end else begin
                r_ref_cnt <= r_ref_cnt + c_REF_W'(1);
            end
            if (w_frame_end) begin
                r_frame <= (r_state == S_HOLD) ? r_msg : baseSeg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_d     <= 1'b0;
            r_ack       <= 1'b0;
            r_msg       <= 32'hFFFF_FFFF;
            r_blink_en  <= 1'b0;
            r_phase     <= 1'b0;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_req_d <= msg.msgReq;
            r_ack   <= w_accept;
            if (w_accept) begin
                r_state     <= S_HOLD;
                r_msg       <= msg.msgSeg;
                r_blink_en  <= msg.msgBlink;
                r_phase     <= 1'b0;
                r_hold_cnt  <= '0;
                r_blink_cnt <= '0;
            end else begin
                case (r_state)
                    S_HOLD: begin
                        if (w_hold_done) begin
                            r_state    <= S_IDLE;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                        end
                        if (w_blink_wrap) begin
                            r_blink_cnt <= '0;
                            r_phase     <= ~r_phase;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Blank decision uses next-cycle state so the registered anode lines up
    // with the blink phase register rather than lagging it by a cycle.
    always_comb begin
        w_blank_nxt = 1'b0;
        if (!w_accept && (r_state == S_HOLD) && !w_hold_done && r_blink_en) begin
            w_blank_nxt = w_blink_wrap ? ~r_phase : r_phase;
        end
    end

    always_comb begin
        w_anode_dec = 4'b1111;
        w_seg_sel   = 8'hFF;
        case (r_idx)
            2'd0: begin
                w_anode_dec = 4'b0111;
                w_seg_sel   = r_frame[31:24];
            end
            2'd1: begin
                w_anode_dec = 4'b1011;
                w_seg_sel   = r_frame[23:16];
            end
            2'd2: begin
                w_anode_dec = 4'b1101;
                w_seg_sel   = r_frame[15:8];
            end
            2'd3: begin
                w_anode_dec = 4'b1110;
                w_seg_sel   = r_frame[7:0];
            end
            default: begin
                w_anode_dec = 4'b1111;
                w_seg_sel   = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anode <= 4'b1111;
            r_seg   <= 8'hFF;
        end else begin
            r_anode <= w_blank_nxt ? 4'b1111 : w_anode_dec;
            r_seg   <= w_seg_sel;
        end
    end

    assign anode       = r_anode;
    assign segOut      = r_seg;
    assign msg.msgAck  = r_ack;
    assign msg.msgBusy = (r_state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_seg_display_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_sched
// Description : Self-checking bench for seg_display_sched (frame scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_sched;

    localparam int REFRESH_DIV = 4;
    localparam int HOLD_CYCLES = 40;
    localparam int BLINK_DIV   = 8;
    localparam int FRAME       = 4 * REFRESH_DIV;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic [31:0] baseSeg = 32'h0;
    logic [3:0]  anode;
    logic [7:0]  segOut;

    seg_display_sched_if u_if ();

    seg_display_sched #(
        .REFRESH_DIV (REFRESH_DIV),
        .HOLD_CYCLES (HOLD_CYCLES),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .baseSeg (baseSeg),
        .msg     (u_if),
        .anode   (anode),
        .segOut  (segOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_n;
        logic [31:0] seg;
        logic        blink;
    } acc_t;

    typedef struct {
        logic [31:0] base;
        logic [7:0]  seg [4];
        logic [3:0]  an  [4];
    } vec_t;

    acc_t        accs[$];
    logic [31:0] exp_frames[$];
    logic [31:0] cur_frame = 32'hFFFF_FFFF;
    int          cyc       = 0;
    bit          mon_en    = 1'b0;
    int          n_chk     = 0;
    int          n_fail    = 0;
    vec_t        tbl [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int last_acc(input int k);
        int r = -1;
        foreach (accs[i]) if (accs[i].edge_n <= k) r = i;
        return r;
    endfunction

    // Frame loaded at edge b shows the message iff it owned the display just before b.
    function automatic logic [31:0] frame_expect(input int b);
        int i = last_acc(b - 1);
        if (i >= 0 && (b - 1 - accs[i].edge_n) < HOLD_CYCLES) return accs[i].seg;
        return baseSeg;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc % FRAME == 0) exp_frames.push_back(frame_expect(cyc));
    endtask

    task automatic go(input int n);
        while (cyc < n) step();
    endtask

    task automatic request(input logic [31:0] seg, input logic blink, input int len);
        u_if.msgSeg   = seg;
        u_if.msgBlink = blink;
        if (!u_if.msgReq) accs.push_back('{edge_n: cyc + 1, seg: seg, blink: blink});
        u_if.msgReq = 1'b1;
        repeat (len) step();
        u_if.msgReq = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        int          pos;
        int          dig;
        int          i;
        logic        busy;
        logic        ack;
        logic        blank;
        logic [3:0]  ea;
        if (mon_en && cyc >= 1) begin
            pos = (cyc - 1) % FRAME;
            dig = pos / REFRESH_DIV;
            if (pos == 0) begin
                if (exp_frames.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL frame_queue at cycle %0d: got empty queue, expected a frame", cyc);
                end else begin
                    cur_frame = exp_frames.pop_front();
                end
            end
            i     = last_acc(cyc);
            busy  = 1'b0;
            ack   = 1'b0;
            blank = 1'b0;
            if (i >= 0) begin
                busy  = (cyc - accs[i].edge_n) < HOLD_CYCLES;
                ack   = (cyc == accs[i].edge_n);
                blank = busy && accs[i].blink && (((cyc - accs[i].edge_n) / BLINK_DIV) % 2 == 1);
            end
            ea = blank ? 4'b1111 : ~(4'b1000 >> dig);
            check("mon_segOut", 32'(segOut), 32'(cur_frame[31 - 8*dig -: 8]));
            check("mon_anode", 32'(anode), 32'(ea));
            check("mon_msgAck", 32'(u_if.msgAck), 32'(ack));
            check("mon_msgBusy", 32'(u_if.msgBusy), 32'(busy));
        end
    end

    initial begin
        u_if.msgSeg   = 32'h0;
        u_if.msgReq   = 1'b0;
        u_if.msgBlink = 1'b0;

        tbl[0].base = 32'h81F34961;
        tbl[0].seg  = '{8'h81, 8'hF3, 8'h49, 8'h61};
        tbl[1].base = 32'hC0A1B2C3;
        tbl[1].seg  = '{8'hC0, 8'hA1, 8'hB2, 8'hC3};
        tbl[2].base = 32'h00FF55AA;
        tbl[2].seg  = '{8'h00, 8'hFF, 8'h55, 8'hAA};
        for (int v = 0; v < 3; v++) tbl[v].an = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

        // Power-on reset, checked without any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_anode", 32'(anode), 32'hF);
        check("rst_segOut", 32'(segOut), 32'hFF);
        check("rst_msgAck", 32'(u_if.msgAck), 32'h0);
        check("rst_msgBusy", 32'(u_if.msgBusy), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc = 0;
        exp_frames.push_back(32'hFFFF_FFFF);
        mon_en = 1'b1;

        // Base-pattern table; each new base is driven mid-frame.
        for (int v = 0; v < 3; v++) begin
            go(32*v + 8);
            baseSeg = tbl[v].base;
            go(32*v + 16);
            for (int p = 0; p < FRAME; p++) begin
                step();
                check("tbl_segOut", 32'(segOut), 32'(tbl[v].seg[p / REFRESH_DIV]));
                check("tbl_anode", 32'(anode), 32'(tbl[v].an[p / REFRESH_DIV]));
            end
        end

        // Single message.
        go(100);
        request(32'h7F7F7F7F, 1'b0, 1);
        check("msg_ack_pulse", 32'(u_if.msgAck), 32'h1);
        step();
        check("msg_ack_drop", 32'(u_if.msgAck), 32'h0);
        go(113);
        check("msg_dashes", 32'(segOut), 32'h7F);
        go(140);
        check("msg_busy_last", 32'(u_if.msgBusy), 32'h1);
        step();
        check("msg_busy_fall", 32'(u_if.msgBusy), 32'h0);
        go(145);
        check("msg_base_return", 32'(segOut), 32'(tbl[2].seg[0]));

        // Preemption at hold cycle 20.
        go(160);
        request(32'h7F7F7F7F, 1'b0, 1);
        go(180);
        request(32'h01010101, 1'b0, 1);
        check("pre_ack", 32'(u_if.msgAck), 32'h1);
        go(193);
        check("pre_eights", 32'(segOut), 32'h01);
        go(220);
        check("pre_busy_last", 32'(u_if.msgBusy), 32'h1);
        step();
        check("pre_busy_fall", 32'(u_if.msgBusy), 32'h0);

        // Held request, then drop one cycle and re-raise.
        go(240);
        request(32'h49494949, 1'b0, 100);
        step();
        request(32'hF3F3F3F3, 1'b0, 1);
        check("held_reaccept_ack", 32'(u_if.msgAck), 32'h1);

        // Blinking message, then the same message without blink.
        go(400);
        request(32'h24242424, 1'b1, 1);
        go(409);
        check("blink_blank", 32'(anode), 32'hF);
        go(417);
        check("blink_visible", 32'(anode), 32'b0111);
        go(460);
        request(32'h24242424, 1'b0, 1);
        go(469);
        check("noblink_visible", 32'(anode), 32'b1011);

        // Asynchronous reset in the middle of a held message.
        go(520);
        request(32'h01010101, 1'b0, 1);
        go(530);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("mid_rst_anode", 32'(anode), 32'hF);
        check("mid_rst_segOut", 32'(segOut), 32'hFF);
        check("mid_rst_msgBusy", 32'(u_if.msgBusy), 32'h0);
        check("mid_rst_msgAck", 32'(u_if.msgAck), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc = 0;
        accs.delete();
        exp_frames.delete();
        exp_frames.push_back(32'hFFFF_FFFF);
        mon_en = 1'b1;
        go(5);
        check("post_rst_blank", 32'(segOut), 32'hFF);
        go(17);
        check("post_rst_base", 32'(segOut), 32'(tbl[2].seg[0]));
        go(48);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
